// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_wb_stage_if #(
  parameter int unsigned AW = 32
);
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_be;
  logic          dmem_ack;
  logic [31:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: data-memory access with lane steering, HI/LO ownership, writeback bundle.
// Optional macro ALIGN_CHECK_EN: flags misaligned half/word accesses via a one-cycle wb_exc pulse.
module mem_wb_stage #(
  parameter int unsigned AW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           mem_result,
  input  logic [31:0]           mem_busB,
  input  logic [31:0]           mem_HL,
  input  logic [63:0]           mem_mult,
  input  logic [31:0]           mem_busA_mux2,
  input  logic [4:0]            mem_rw,
  input  logic                  mem_regWr,
  input  logic                  mem_multWr,
  input  logic                  mem_Lowin,
  input  logic                  mem_Highin,
  input  logic                  mem_memwr,
  input  logic [1:0]            mem_memtoreg,
  input  logic [5:0]            mem_op,
  output logic                  stall,
  mem_wb_stage_if.master        dmem,
  output logic [31:0]           hi,
  output logic [31:0]           lo,
  output logic [31:0]           wb_wdata,
  output logic [4:0]            wb_rw,
  output logic                  wb_regWr,
  output logic                  wb_exc
);

  localparam int unsigned OPW = 6;
  localparam logic [OPW-1:0] OP_LB  = 6'h20;
  localparam logic [OPW-1:0] OP_LH  = 6'h21;
  localparam logic [OPW-1:0] OP_LW  = 6'h23;
  localparam logic [OPW-1:0] OP_LBU = 6'h24;
  localparam logic [OPW-1:0] OP_LHU = 6'h25;
  localparam logic [OPW-1:0] OP_SB  = 6'h28;
  localparam logic [OPW-1:0] OP_SH  = 6'h29;
  localparam logic [OPW-1:0] OP_SW  = 6'h2B;

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic [4:0]  wb_rw_q, wb_rw_d;
  logic        wb_regwr_q, wb_regwr_d;
  logic        wb_exc_q, wb_exc_d;

  logic [1:0]  a;
  logic        is_load, is_store, sz_byte, sz_half, ld_unsigned;
  logic        misalign, acc;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data, wdata_c, wsel;
  logic [3:0]  be_c;
  logic        req_c, stall_c, complete;

  // Opcode decode; loads need memtoreg=01, stores need memwr=1.
  always_comb begin
    a           = mem_result[1:0];
    is_load     = 1'b0;
    is_store    = 1'b0;
    sz_byte     = 1'b0;
    sz_half     = 1'b0;
    ld_unsigned = 1'b0;
    case (mem_op)
      OP_LB:  begin is_load = (mem_memtoreg == 2'b01); sz_byte = 1'b1; end
      OP_LH:  begin is_load = (mem_memtoreg == 2'b01); sz_half = 1'b1; end
      OP_LW:  begin is_load = (mem_memtoreg == 2'b01); end
      OP_LBU: begin is_load = (mem_memtoreg == 2'b01); sz_byte = 1'b1; ld_unsigned = 1'b1; end
      OP_LHU: begin is_load = (mem_memtoreg == 2'b01); sz_half = 1'b1; ld_unsigned = 1'b1; end
      OP_SB:  begin is_store = mem_memwr; sz_byte = 1'b1; end
      OP_SH:  begin is_store = mem_memwr; sz_half = 1'b1; end
      OP_SW:  begin is_store = mem_memwr; end
      default: ;
    endcase
`ifdef ALIGN_CHECK_EN
    misalign = (is_load | is_store) &
               ((sz_half & a[0]) | (~sz_byte & ~sz_half & (a != 2'b00)));
`else
    misalign = 1'b0;
`endif
    acc = (is_load | is_store) & ~misalign;
  end

  // Lane steering for byte enables, store replication and load extraction.
  always_comb begin
    case (a)
      2'd0:    byte_v = dmem.dmem_rdata[7:0];
      2'd1:    byte_v = dmem.dmem_rdata[15:8];
      2'd2:    byte_v = dmem.dmem_rdata[23:16];
      default: byte_v = dmem.dmem_rdata[31:24];
    endcase
    half_v = a[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    if (sz_byte) begin
      be_c      = 4'b0001 << a;
      wdata_c   = {4{mem_busB[7:0]}};
      load_data = ld_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
    end else if (sz_half) begin
      be_c      = a[1] ? 4'b1100 : 4'b0011;
      wdata_c   = {2{mem_busB[15:0]}};
      load_data = ld_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
    end else begin
      be_c      = 4'b1111;
      wdata_c   = mem_busB;
      load_data = dmem.dmem_rdata;
    end
  end

  // Access FSM: request held until ack, upstream stalled meanwhile; reset overrides everything.
  always_comb begin
    state_d  = state_q;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    complete = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      req_c    = acc;
      stall_c  = acc & ~dmem.dmem_ack;
      complete = ~stall_c;
      case (state_q)
        ST_IDLE: if (stall_c)  state_d = ST_WAIT;
        ST_WAIT: if (!stall_c) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Writeback bundle and HI/LO next values; a stalled edge inserts a bubble.
  always_comb begin
    case (mem_memtoreg)
      2'b00:   wsel = mem_result;
      2'b01:   wsel = load_data;
      2'b10:   wsel = mem_HL;
      default: wsel = 32'b0;
    endcase
    wb_wdata_d = wb_wdata_q;
    wb_rw_d    = wb_rw_q;
    wb_regwr_d = 1'b0;
    wb_exc_d   = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (complete) begin
      wb_wdata_d = wsel;
      wb_rw_d    = mem_rw;
      wb_regwr_d = mem_regWr & ~misalign;
      wb_exc_d   = misalign;
      if (mem_multWr) begin
        {hi_d, lo_d} = mem_mult;
      end else begin
        if (mem_Highin) hi_d = mem_busA_mux2;
        if (mem_Lowin)  lo_d = mem_busA_mux2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hi_q       <= 32'b0;
      lo_q       <= 32'b0;
      wb_wdata_q <= 32'b0;
      wb_rw_q    <= 5'b0;
      wb_regwr_q <= 1'b0;
      wb_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wb_wdata_q <= wb_wdata_d;
      wb_rw_q    <= wb_rw_d;
      wb_regwr_q <= wb_regwr_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

  assign stall           = stall_c;
  assign dmem.dmem_req   = req_c;
  assign dmem.dmem_we    = req_c & is_store;
  assign dmem.dmem_addr  = {mem_result[AW-1:2], 2'b00};
  assign dmem.dmem_wdata = wdata_c;
  assign dmem.dmem_be    = req_c ? be_c : 4'b0000;
  assign hi              = hi_q;
  assign lo              = lo_q;
  assign wb_wdata        = wb_wdata_q;
  assign wb_rw           = wb_rw_q;
  assign wb_regWr        = wb_regwr_q;
  assign wb_exc          = wb_exc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected writebacks queued at issue, popped at completion.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] mem_result, mem_busB, mem_HL, mem_busA_mux2;
  logic [63:0] mem_mult;
  logic [4:0]  mem_rw;
  logic        mem_regWr, mem_multWr, mem_Lowin, mem_Highin, mem_memwr;
  logic [1:0]  mem_memtoreg;
  logic [5:0]  mem_op;
  logic        stall;
  logic [31:0] hi, lo, wb_wdata;
  logic [4:0]  wb_rw;
  logic        wb_regWr, wb_exc;

  mem_wb_stage_if #(.AW(32)) dbus();

  mem_wb_stage #(.AW(32)) dut (
    .clk(clk), .rst(rst),
    .mem_result(mem_result), .mem_busB(mem_busB), .mem_HL(mem_HL),
    .mem_mult(mem_mult), .mem_busA_mux2(mem_busA_mux2), .mem_rw(mem_rw),
    .mem_regWr(mem_regWr), .mem_multWr(mem_multWr), .mem_Lowin(mem_Lowin),
    .mem_Highin(mem_Highin), .mem_memwr(mem_memwr), .mem_memtoreg(mem_memtoreg),
    .mem_op(mem_op), .stall(stall), .dmem(dbus),
    .hi(hi), .lo(lo), .wb_wdata(wb_wdata), .wb_rw(wb_rw),
    .wb_regWr(wb_regWr), .wb_exc(wb_exc)
  );

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  rw;
    logic        regwr;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cur_hi = 32'b0, cur_lo = 32'b0, cur_wd = 32'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    mem_result = 32'b0; mem_busB = 32'b0; mem_HL = 32'b0; mem_busA_mux2 = 32'b0;
    mem_mult = 64'b0; mem_rw = 5'b0; mem_regWr = 1'b0; mem_multWr = 1'b0;
    mem_Lowin = 1'b0; mem_Highin = 1'b0; mem_memwr = 1'b0; mem_memtoreg = 2'b00;
    mem_op = 6'h00; dbus.dmem_ack = 1'b0; dbus.dmem_rdata = 32'b0;
  endtask

  // Applies ack after ack_dly stalled cycles, checks bubbles, then pops and checks the writeback.
  task automatic run_access(input int ack_dly, input logic [31:0] rdata, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    for (int c = 0; c <= ack_dly; c++) begin
      dbus.dmem_ack   = (c == ack_dly);
      dbus.dmem_rdata = rdata;
      #1;
      n_checks++;
      if (stall !== (c < ack_dly)) begin
        n_fail++; $display("FAIL stall cyc=%0d got=%b exp=%b", c, stall, (c < ack_dly));
      end
      step();
      if (c < ack_dly) begin
        n_checks++;
        if (wb_regWr !== 1'b0 || wb_wdata !== cur_wd || hi !== cur_hi || lo !== cur_lo) begin
          n_fail++;
          $display("FAIL bubble cyc=%0d regWr=%b wdata=%h hi=%h lo=%h exp regWr=0 wdata=%h hi=%h lo=%h",
                   c, wb_regWr, wb_wdata, hi, lo, cur_wd, cur_hi, cur_lo);
        end
      end else begin
        got = sb_q.pop_front();
        n_checks++;
        if (wb_wdata !== got.wdata || wb_rw !== got.rw || wb_regWr !== got.regwr || wb_exc !== 1'b0) begin
          n_fail++;
          $display("FAIL wb got wdata=%h rw=%0d regWr=%b exc=%b exp wdata=%h rw=%0d regWr=%b exc=0",
                   wb_wdata, wb_rw, wb_regWr, wb_exc, got.wdata, got.rw, got.regwr);
        end
        n_checks++;
        if (hi !== got.hi || lo !== got.lo) begin
          n_fail++; $display("FAIL hilo got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, got.hi, got.lo);
        end
        cur_hi = got.hi; cur_lo = got.lo; cur_wd = got.wdata;
      end
    end
    dbus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_nop();
    mem_op = 6'h23; mem_memtoreg = 2'b01; mem_result = 32'h10;
    step(); step();
    n_checks++;
    if (stall !== 1'b0 || dbus.dmem_req !== 1'b0 || dbus.dmem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_comb stall=%b req=%b we=%b exp 0", stall, dbus.dmem_req, dbus.dmem_we);
    end
    n_checks++;
    if (hi !== 32'b0 || lo !== 32'b0 || wb_wdata !== 32'b0 || wb_rw !== 5'b0 ||
        wb_regWr !== 1'b0 || wb_exc !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs hi=%h lo=%h wd=%h rw=%0d regWr=%b exc=%b exp all 0",
                         hi, lo, wb_wdata, wb_rw, wb_regWr, wb_exc);
    end
    drive_nop();
    rst = 1'b0;
    step();
  endtask

  task automatic test_lw_fast();
    exp_t e;
    drive_nop();
    mem_op = 6'h23; mem_memtoreg = 2'b01; mem_result = 32'h10; mem_rw = 5'd5; mem_regWr = 1'b1;
    #1;
    n_checks++;
    if (dbus.dmem_req !== 1'b1 || dbus.dmem_we !== 1'b0 || dbus.dmem_addr !== 32'h10 || dbus.dmem_be !== 4'b1111) begin
      n_fail++; $display("FAIL lw_bus req=%b we=%b addr=%h be=%b exp 1 0 00000010 1111",
                         dbus.dmem_req, dbus.dmem_we, dbus.dmem_addr, dbus.dmem_be);
    end
    e = '{wdata: 32'hDEADBEEF, rw: 5'd5, regwr: 1'b1, hi: cur_hi, lo: cur_lo};
    run_access(0, 32'hDEADBEEF, e);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } ld_t;

  task automatic test_loads();
    ld_t  tbl[6];
    exp_t e;
    tbl[0] = '{op: 6'h20, addr: 32'h13, rdata: 32'h80112233, be: 4'b1000, exp: 32'hFFFFFF80};
    tbl[1] = '{op: 6'h24, addr: 32'h13, rdata: 32'h80112233, be: 4'b1000, exp: 32'h00000080};
    tbl[2] = '{op: 6'h20, addr: 32'h11, rdata: 32'h80112233, be: 4'b0010, exp: 32'h00000022};
    tbl[3] = '{op: 6'h21, addr: 32'h22, rdata: 32'h80011234, be: 4'b1100, exp: 32'hFFFF8001};
    tbl[4] = '{op: 6'h25, addr: 32'h20, rdata: 32'h80011234, be: 4'b0011, exp: 32'h00001234};
    tbl[5] = '{op: 6'h25, addr: 32'h22, rdata: 32'h80011234, be: 4'b1100, exp: 32'h00008001};
    for (int i = 0; i < 6; i++) begin
      drive_nop();
      mem_op = tbl[i].op; mem_memtoreg = 2'b01; mem_result = tbl[i].addr;
      mem_rw = 5'(i + 1); mem_regWr = 1'b1;
      #1;
      n_checks++;
      if (dbus.dmem_be !== tbl[i].be || dbus.dmem_addr !== {tbl[i].addr[31:2], 2'b00}) begin
        n_fail++; $display("FAIL load_bus[%0d] be=%b addr=%h exp be=%b addr=%h", i, dbus.dmem_be,
                           dbus.dmem_addr, tbl[i].be, {tbl[i].addr[31:2], 2'b00});
      end
      e = '{wdata: tbl[i].exp, rw: 5'(i + 1), regwr: 1'b1, hi: cur_hi, lo: cur_lo};
      run_access((i < 2) ? 3 : (i % 2), tbl[i].rdata, e);
    end
  endtask

  task automatic test_stores();
    logic [5:0]  ops[3]  = '{6'h29, 6'h28, 6'h2B};
    logic [31:0] adr[3]  = '{32'h06, 32'h01, 32'h08};
    logic [31:0] bsb[3]  = '{32'h0000ABCD, 32'h123456EF, 32'hCAFEF00D};
    logic [3:0]  ebe[3]  = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ewd[3]  = '{32'hABCDABCD, 32'hEFEFEFEF, 32'hCAFEF00D};
    logic [31:0] eadr[3] = '{32'h04, 32'h00, 32'h08};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive_nop();
      mem_op = ops[i]; mem_memwr = 1'b1; mem_result = adr[i]; mem_busB = bsb[i];
      #1;
      n_checks++;
      if (dbus.dmem_req !== 1'b1 || dbus.dmem_we !== 1'b1 || dbus.dmem_be !== ebe[i] ||
          dbus.dmem_wdata !== ewd[i] || dbus.dmem_addr !== eadr[i]) begin
        n_fail++; $display("FAIL store_bus[%0d] req=%b we=%b be=%b wdata=%h addr=%h exp 1 1 %b %h %h",
                           i, dbus.dmem_req, dbus.dmem_we, dbus.dmem_be, dbus.dmem_wdata,
                           dbus.dmem_addr, ebe[i], ewd[i], eadr[i]);
      end
      e = '{wdata: adr[i], rw: 5'd0, regwr: 1'b0, hi: cur_hi, lo: cur_lo};
      run_access(i, 32'h0, e);
    end
  endtask

  task automatic test_hilo();
    exp_t e;
    drive_nop(); mem_multWr = 1'b1; mem_mult = 64'h00000001_00000002;
    e = '{wdata: 32'h0, rw: 5'd0, regwr: 1'b0, hi: 32'h1, lo: 32'h2};
    run_access(0, 32'h0, e);
    drive_nop(); mem_Lowin = 1'b1; mem_busA_mux2 = 32'h7;
    e = '{wdata: 32'h0, rw: 5'd0, regwr: 1'b0, hi: 32'h1, lo: 32'h7};
    run_access(0, 32'h0, e);
    drive_nop(); mem_Lowin = 1'b1; mem_Highin = 1'b1; mem_busA_mux2 = 32'h9;
    e = '{wdata: 32'h0, rw: 5'd0, regwr: 1'b0, hi: 32'h9, lo: 32'h9};
    run_access(0, 32'h0, e);
    drive_nop(); mem_multWr = 1'b1; mem_Highin = 1'b1; mem_busA_mux2 = 32'hFF;
    mem_mult = 64'h00000003_00000004;
    e = '{wdata: 32'h0, rw: 5'd0, regwr: 1'b0, hi: 32'h3, lo: 32'h4};
    run_access(0, 32'h0, e);
    // HI write rides on a stalled load and must land only at completion.
    drive_nop(); mem_op = 6'h23; mem_memtoreg = 2'b01; mem_result = 32'h40; mem_rw = 5'd7;
    mem_regWr = 1'b1; mem_Highin = 1'b1; mem_busA_mux2 = 32'hAA;
    e = '{wdata: 32'h11, rw: 5'd7, regwr: 1'b1, hi: 32'hAA, lo: 32'h4};
    run_access(2, 32'h11, e);
    drive_nop(); mem_memtoreg = 2'b10; mem_HL = 32'h55; mem_rw = 5'd9; mem_regWr = 1'b1;
    e = '{wdata: 32'h55, rw: 5'd9, regwr: 1'b1, hi: 32'hAA, lo: 32'h4};
    run_access(0, 32'h0, e);
    drive_nop(); mem_memtoreg = 2'b11; mem_result = 32'h1234; mem_rw = 5'd10; mem_regWr = 1'b1;
    e = '{wdata: 32'h0, rw: 5'd10, regwr: 1'b1, hi: 32'hAA, lo: 32'h4};
    run_access(0, 32'h0, e);
  endtask

  task automatic test_reset_in_wait();
    drive_nop();
    mem_op = 6'h23; mem_memtoreg = 2'b01; mem_result = 32'h80; mem_rw = 5'd3; mem_regWr = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL wait_stall cyc=%0d got=%b exp=1", c, stall); end
      step();
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || dbus.dmem_req !== 1'b0 || dbus.dmem_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_comb stall=%b req=%b we=%b exp 0", stall, dbus.dmem_req, dbus.dmem_we);
    end
    step();
    n_checks++;
    if (hi !== 32'b0 || lo !== 32'b0 || wb_regWr !== 1'b0 || wb_wdata !== 32'b0 || wb_rw !== 5'b0) begin
      n_fail++; $display("FAIL rst_wait_regs hi=%h lo=%h regWr=%b wd=%h rw=%0d exp all 0",
                         hi, lo, wb_regWr, wb_wdata, wb_rw);
    end
    drive_nop();
    rst = 1'b0;
    dbus.dmem_ack = 1'b1; dbus.dmem_rdata = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (stall !== 1'b0 || dbus.dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL late_ack_comb stall=%b req=%b exp 0", stall, dbus.dmem_req);
    end
    step();
    n_checks++;
    if (wb_regWr !== 1'b0 || wb_wdata !== 32'b0 || hi !== 32'b0 || lo !== 32'b0) begin
      n_fail++; $display("FAIL late_ack regWr=%b wd=%h hi=%h lo=%h exp all 0", wb_regWr, wb_wdata, hi, lo);
    end
    dbus.dmem_ack = 1'b0;
    cur_hi = 32'b0; cur_lo = 32'b0; cur_wd = 32'b0;
  endtask

`ifdef ALIGN_CHECK_EN
  task automatic test_align();
    logic [5:0]  ops[2] = '{6'h23, 6'h29};
    logic [31:0] adr[2] = '{32'h02, 32'h03};
    for (int i = 0; i < 2; i++) begin
      drive_nop();
      mem_op = ops[i]; mem_result = adr[i]; mem_rw = 5'd3; mem_regWr = (i == 0);
      mem_memtoreg = (i == 0) ? 2'b01 : 2'b00; mem_memwr = (i == 1);
      #1;
      n_checks++;
      if (dbus.dmem_req !== 1'b0 || stall !== 1'b0) begin
        n_fail++; $display("FAIL align_comb[%0d] req=%b stall=%b exp 0 0", i, dbus.dmem_req, stall);
      end
      step();
      n_checks++;
      if (wb_exc !== 1'b1 || wb_regWr !== 1'b0) begin
        n_fail++; $display("FAIL align_exc[%0d] exc=%b regWr=%b exp 1 0", i, wb_exc, wb_regWr);
      end
      drive_nop();
      step();
      n_checks++;
      if (wb_exc !== 1'b0) begin n_fail++; $display("FAIL align_pulse[%0d] exc=%b exp 0", i, wb_exc); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw_fast();
    test_loads();
    test_stores();
    test_hilo();
    test_reset_in_wait();
`ifdef ALIGN_CHECK_EN
    test_align();
`endif
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
